// File: rtl/central_ctrl_fsm.sv
// Top-level bodydrums controller: latches the user's selection, runs the memory start handshake, sequences play/record.
// Optional feature: define CENTRAL_CTRL_LOOP_EN to restart playback automatically at the end of a song.
module central_ctrl_fsm #(
    parameter int unsigned NUM_FX    = 7,
    parameter int unsigned FXVAL_W   = 17,
    parameter int unsigned SONG_W    = 4,
    parameter int unsigned SKIP_BASE = 6,
    parameter int unsigned SKIP_GAP  = 2,
    parameter int unsigned START_TO  = 255,
    parameter int unsigned ELAPSED_W = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 but_ent,
    input  logic                 pause_sw,
    input  logic [NUM_FX-1:0]    effects_sw,
    input  logic                 record_mode_sel,
    input  logic [SONG_W-1:0]    song_name_sel,
    input  logic [FXVAL_W-1:0]   effect_values_sel,
    input  logic                 song_done,
    input  logic                 mem_ready,
    input  logic                 tick,
    output logic [2:0]           state,
    output logic [NUM_FX-1:0]    effects,
    output logic [FXVAL_W-1:0]   effect_values,
    output logic                 record_mode,
    output logic [SONG_W-1:0]    song_name,
    output logic [SONG_W:0]      song_choice,
    output logic                 start_song,
    output logic                 pause_song,
    output logic [ELAPSED_W-1:0] elapsed,
    output logic                 start_err
);

    localparam int unsigned CNT_W = (START_TO > 1) ? $clog2(START_TO) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_PLAY  = 3'd2,
        S_REC   = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t             state_q;
    logic               but_prev;
    logic               pause_q;
    logic               press;
    logic [CNT_W-1:0]   to_cnt;
    logic [SONG_W:0]    remap;

    assign state = state_q;

    always_comb begin
        press = but_ent & ~but_prev;
        if (int'(song_name_sel) < int'(SKIP_BASE))
            remap = {1'b0, song_name_sel};
        else
            remap = {1'b0, song_name_sel} + (SONG_W+1)'(SKIP_GAP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            but_prev      <= 1'b1;
            pause_q       <= 1'b1;
            to_cnt        <= '0;
            effects       <= '0;
            effect_values <= '0;
            record_mode   <= 1'b0;
            song_name     <= '0;
            song_choice   <= '0;
            start_song    <= 1'b0;
            pause_song    <= 1'b1;
            elapsed       <= '0;
            start_err     <= 1'b0;
        end else begin
            but_prev <= but_ent;
            pause_q  <= pause_sw;

            // Counts against the pause actually presented to memory/audio.
            if ((state_q == S_PLAY || state_q == S_REC) && tick && !pause_song && elapsed != '1)
                elapsed <= elapsed + 1'b1;

            case (state_q)
                S_IDLE: begin
                    pause_song <= 1'b1;
                    start_song <= 1'b0;
                    if (press) begin
                        effects       <= effects_sw;
                        effect_values <= effect_values_sel;
                        record_mode   <= record_mode_sel;
                        song_name     <= song_name_sel;
                        song_choice   <= remap;
                        elapsed       <= '0;
                        start_err     <= 1'b0;
                        to_cnt        <= '0;
                        start_song    <= 1'b1;
                        state_q       <= S_START;
                    end
                end
                S_START: begin
                    pause_song <= 1'b1;
                    if (mem_ready) begin
                        start_song <= 1'b0;
                        state_q    <= record_mode ? S_REC : S_PLAY;
                    end else if (to_cnt == CNT_W'(START_TO - 1)) begin
                        start_song <= 1'b0;
                        start_err  <= 1'b1;
                        state_q    <= S_FAULT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_PLAY, S_REC: begin
                    if (song_done || press) begin
                        pause_song <= 1'b1;
                        state_q    <= S_IDLE;
`ifdef CENTRAL_CTRL_LOOP_EN
                        // A simultaneous press still wins and leaves playback.
                        if (state_q == S_PLAY && song_done && !press) begin
                            to_cnt     <= '0;
                            start_song <= 1'b1;
                            state_q    <= S_START;
                        end
`endif
                    end else begin
                        pause_song <= pause_q;
                    end
                end
                S_FAULT: begin
                    pause_song <= 1'b1;
                    start_song <= 1'b0;
                    if (press)
                        state_q <= S_IDLE;
                end
                default: begin
                    pause_song <= 1'b1;
                    start_song <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_central_ctrl_fsm.sv
// Scoreboard bench for central_ctrl_fsm: expected state transitions and output values are queued
// by the stimulus process and compared by an independent monitor on the falling clock edge.
module tb_central_ctrl_fsm;

    localparam int unsigned NUM_FX    = 7;
    localparam int unsigned FXVAL_W   = 17;
    localparam int unsigned SONG_W    = 4;
    localparam int unsigned ELAPSED_W = 12;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 but_ent, pause_sw, record_mode_sel, song_done, mem_ready, tick;
    logic [NUM_FX-1:0]    effects_sw;
    logic [SONG_W-1:0]    song_name_sel;
    logic [FXVAL_W-1:0]   effect_values_sel;
    logic [2:0]           state;
    logic [NUM_FX-1:0]    effects;
    logic [FXVAL_W-1:0]   effect_values;
    logic                 record_mode, start_song, pause_song, start_err;
    logic [SONG_W-1:0]    song_name;
    logic [SONG_W:0]      song_choice;
    logic [ELAPSED_W-1:0] elapsed;

    central_ctrl_fsm #(
        .NUM_FX(NUM_FX), .FXVAL_W(FXVAL_W), .SONG_W(SONG_W), .SKIP_BASE(6),
        .SKIP_GAP(2), .START_TO(255), .ELAPSED_W(ELAPSED_W)
    ) dut (
        .clk(clk), .reset(reset), .but_ent(but_ent), .pause_sw(pause_sw),
        .effects_sw(effects_sw), .record_mode_sel(record_mode_sel),
        .song_name_sel(song_name_sel), .effect_values_sel(effect_values_sel),
        .song_done(song_done), .mem_ready(mem_ready), .tick(tick),
        .state(state), .effects(effects), .effect_values(effect_values),
        .record_mode(record_mode), .song_name(song_name), .song_choice(song_choice),
        .start_song(start_song), .pause_song(pause_song), .elapsed(elapsed),
        .start_err(start_err)
    );

    always #5 clk = ~clk;

    localparam int unsigned F_STATE = 0, F_START = 1, F_PAUSE = 2, F_ELAPSED = 3, F_ERR = 4,
                            F_CHOICE = 5, F_NAME = 6, F_REC = 7, F_FX = 8, F_FXVAL = 9;

    typedef struct {
        string       name;
        int unsigned field;
        logic [31:0] exp;
    } chk_t;

    chk_t       chk_q[$];
    logic [2:0] st_q[$];
    int         tests = 0;
    int         fails = 0;

    function automatic logic [31:0] actual(int unsigned f);
        case (f)
            F_STATE:   return 32'(state);
            F_START:   return 32'(start_song);
            F_PAUSE:   return 32'(pause_song);
            F_ELAPSED: return 32'(elapsed);
            F_ERR:     return 32'(start_err);
            F_CHOICE:  return 32'(song_choice);
            F_NAME:    return 32'(song_name);
            F_REC:     return 32'(record_mode);
            F_FX:      return 32'(effects);
            F_FXVAL:   return 32'(effect_values);
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string n, input int unsigned f, input logic [31:0] v);
        chk_t c;
        c.name  = n;
        c.field = f;
        c.exp   = v;
        chk_q.push_back(c);
    endtask

    task automatic expect_state(input logic [2:0] s);
        st_q.push_back(s);
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_btn();
        but_ent = 1'b1;
        step(1);
        but_ent = 1'b0;
    endtask

    // Monitor: every state change must match the next queued transition; value checks drain each cycle.
    initial begin
        logic [2:0] prev;
        logic [2:0] e;
        chk_t       c;
        prev = 3'd0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                prev = state;
            end else if (state !== prev) begin
                tests++;
                if (st_q.size() == 0) begin
                    fails++;
                    $display("FAIL transition: unexpected state %0d (from %0d)", state, prev);
                end else begin
                    e = st_q.pop_front();
                    if (state !== e) begin
                        fails++;
                        $display("FAIL transition: got state %0d expected %0d", state, e);
                    end
                end
                prev = state;
            end
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                tests++;
                if (actual(c.field) !== c.exp) begin
                    fails++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, actual(c.field), c.exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; but_ent = 1'b1; pause_sw = 1'b0; record_mode_sel = 1'b0;
        song_done = 1'b0; mem_ready = 1'b0; tick = 1'b0;
        effects_sw = '0; song_name_sel = '0; effect_values_sel = '0;

        // Reset values, with the button held through reset
        step(3);
        expect_val("rst_state", F_STATE, 0);
        expect_val("rst_start", F_START, 0);
        expect_val("rst_pause", F_PAUSE, 1);
        expect_val("rst_elapsed", F_ELAPSED, 0);
        expect_val("rst_err", F_ERR, 0);
        expect_val("rst_choice", F_CHOICE, 0);
        expect_val("rst_fx", F_FX, 0);
        expect_val("rst_fxval", F_FXVAL, 0);
        reset = 1'b0;
        step(3);
        expect_val("held_btn_state", F_STATE, 0);
        expect_val("held_btn_pause", F_PAUSE, 1);
        but_ent = 1'b0;
        step(1);

        // Capture sel=7 playback, mem_ready arrives on the third START edge
        song_name_sel = 4'd7; record_mode_sel = 1'b0; effects_sw = 7'h55; effect_values_sel = 17'h1ABCD;
        expect_state(3'd1);
        press_btn();
        expect_val("cap_choice7", F_CHOICE, 9);
        expect_val("cap_name", F_NAME, 7);
        expect_val("cap_fx", F_FX, 32'h55);
        expect_val("cap_fxval", F_FXVAL, 32'h1ABCD);
        expect_val("cap_rec", F_REC, 0);
        expect_val("start_c1", F_START, 1);
        step(2);
        expect_val("start_c3", F_START, 1);
        mem_ready = 1'b1;
        expect_state(3'd2);
        step(1);
        mem_ready = 1'b0;
        expect_val("play_state", F_STATE, 2);
        expect_val("play_start_drop", F_START, 0);
        expect_val("play_pause_entry", F_PAUSE, 1);
        song_name_sel = 4'd0; effects_sw = '0; effect_values_sel = '0;
        expect_val("latched_hold", F_CHOICE, 9);

        // Elapsed counts only unpaused ticks; pause_song lags the registered switch
        step(1);
        expect_val("play_unpaused", F_PAUSE, 0);
        for (int i = 0; i < 10; i++) begin
            tick = 1'b1; step(1); tick = 1'b0; step(1);
        end
        expect_val("elapsed10", F_ELAPSED, 10);
        pause_sw = 1'b1;
        step(1);
        expect_val("pause_lag", F_PAUSE, 0);
        step(1);
        expect_val("pause_on", F_PAUSE, 1);
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1; step(1); tick = 1'b0; step(1);
        end
        expect_val("elapsed_paused", F_ELAPSED, 10);
        pause_sw = 1'b0;
        step(2);
        expect_val("pause_off", F_PAUSE, 0);

        // song_done together with a press: one return to IDLE, no re-start
        expect_state(3'd0);
        song_done = 1'b1; but_ent = 1'b1;
        step(1);
        song_done = 1'b0;
        expect_val("done_press_state", F_STATE, 0);
        expect_val("done_press_pause", F_PAUSE, 1);
        step(3);
        but_ent = 1'b0;
        expect_val("done_press_stay", F_STATE, 0);
        step(1);

        // Record mode, song index just below the remap base; song_done ends recording
        song_name_sel = 4'd5; record_mode_sel = 1'b1; effects_sw = 7'h0A; effect_values_sel = 17'h00042;
        expect_state(3'd1);
        press_btn();
        expect_val("cap_choice5", F_CHOICE, 5);
        expect_val("cap_rec1", F_REC, 1);
        expect_val("elapsed_cleared", F_ELAPSED, 0);
        mem_ready = 1'b1;
        expect_state(3'd3);
        step(1);
        mem_ready = 1'b0;
        expect_val("rec_state", F_STATE, 3);
        step(2);
        expect_state(3'd0);
        song_done = 1'b1;
        step(1);
        song_done = 1'b0;
        expect_val("rec_done_idle", F_STATE, 0);
        step(1);

        // Start timeout at the remap base; a press in START is ignored
        song_name_sel = 4'd6; record_mode_sel = 1'b0;
        expect_state(3'd1);
        press_btn();
        expect_val("cap_choice6", F_CHOICE, 8);
        step(3);
        press_btn();
        expect_val("start_press_ignored", F_STATE, 1);
        step(250);
        expect_val("to_last_start", F_STATE, 1);
        expect_val("to_last_start_song", F_START, 1);
        expect_val("to_last_err", F_ERR, 0);
        expect_state(3'd4);
        step(1);
        expect_val("fault_state", F_STATE, 4);
        expect_val("fault_err", F_ERR, 1);
        expect_val("fault_start_drop", F_START, 0);
        expect_val("fault_pause", F_PAUSE, 1);
        step(2);
        expect_state(3'd0);
        press_btn();
        expect_val("fault_exit", F_STATE, 0);
        expect_val("err_sticky", F_ERR, 1);
        step(1);

        // Top song index, elapsed saturation, then end-of-song behaviour
        song_name_sel = 4'd15; effects_sw = 7'h7F; effect_values_sel = 17'h1FFFF;
        expect_state(3'd1);
        press_btn();
        expect_val("cap_choice15", F_CHOICE, 17);
        expect_val("err_cleared", F_ERR, 0);
        expect_val("cap_fx_all", F_FX, 32'h7F);
        mem_ready = 1'b1;
        expect_state(3'd2);
        step(1);
        mem_ready = 1'b0;
        step(2);
        tick = 1'b1;
        step(4200);
        tick = 1'b0;
        expect_val("elapsed_sat", F_ELAPSED, 32'hFFF);
`ifdef CENTRAL_CTRL_LOOP_EN
        expect_state(3'd1);
        song_done = 1'b1;
        step(1);
        song_done = 1'b0;
        expect_val("loop_restart", F_STATE, 1);
        expect_val("loop_choice", F_CHOICE, 17);
        expect_val("loop_start_song", F_START, 1);
        expect_val("loop_elapsed_kept", F_ELAPSED, 32'hFFF);
        mem_ready = 1'b1;
        expect_state(3'd2);
        step(1);
        mem_ready = 1'b0;
`else
        expect_state(3'd0);
        song_done = 1'b1;
        step(1);
        song_done = 1'b0;
        expect_val("done_idle", F_STATE, 0);
        expect_val("done_choice_kept", F_CHOICE, 17);
        step(1);
        expect_state(3'd1);
        press_btn();
        mem_ready = 1'b1;
        expect_state(3'd2);
        step(1);
        mem_ready = 1'b0;
`endif
        step(2);
        expect_state(3'd0);
        press_btn();
        expect_val("play_press_idle", F_STATE, 0);
        expect_val("play_press_pause", F_PAUSE, 1);
        step(3);

        tests++;
        if (st_q.size() != 0) begin
            fails++;
            $display("FAIL missing_transitions: got %0d pending expected 0", st_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
